// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and idle line level for the serial transmitter
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam logic IDLE_SDO = 1'b0;

endpackage

// File: rtl/piso_bitcnt.sv
// rtl/piso_bitcnt.sv - enable-gated bit counter with clear and terminal-count flag
module piso_bitcnt #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [CW-1:0] count;

    // Saturates at WIDTH-1 so the count can never wrap past the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter paced by a bit-rate tick
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    piso_state_t      state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             sdo_d;
    logic             done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tc;

    piso_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            sdo   <= IDLE_SDO;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            sdo   <= sdo_d;
            done  <= done_d;
        end
    end

    // The bit currently on sdo always sits at the outgoing end of shreg.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        sdo_d   = sdo;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                sdo_d = IDLE_SDO;
                if (load_valid) begin
                    state_d = SHIFT;
                    shreg_d = load_data;
                    sdo_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (tc) begin
                        state_d = IDLE;
                        sdo_d   = IDLE_SDO;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en  = 1'b1;
                        shreg_d = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};
                        sdo_d   = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state == SHIFT);
    assign load_ready = (state == IDLE);

endmodule
